// File: rtl/lut6_2_cfg_pkg.sv
// Shared types and helpers for the reconfigurable LUT6_2: FSM states, table/select widths,
// and the load-length and shift-width legality helpers.
package lut6_2_cfg_pkg;

    localparam int LUT_BITS = 64;
    localparam int SEL_W    = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } cfg_state_t;

    function automatic bit bpc_legal(input int b);
        return (b == 1) || (b == 2) || (b == 4) || (b == 8) ||
               (b == 16) || (b == 32) || (b == 64);
    endfunction

    function automatic int shift_cycles(input int b);
        return LUT_BITS / b;
    endfunction

endpackage

// File: rtl/lut6_2_dyn_lookup.sv
// Registered O5/O6 mux over a run-time table: 1-cycle latency, one lookup per cycle, no backpressure.
// Outputs hold their last value while no lookup is requested.
module lut6_2_dyn_lookup
    import lut6_2_cfg_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic [LUT_BITS-1:0] i_table,
    input  logic                i_sel_valid,
    input  logic [SEL_W-1:0]    i_sel,
    output logic                o_out_valid,
    output logic                o_o5,
    output logic                o_o6
);

    logic r_out_valid;
    logic r_o5;
    logic r_o6;
    logic [SEL_W-1:0] w_sel5;

    // O5 ignores I5, i.e. it always reads the lower half of the table
    assign w_sel5 = {1'b0, i_sel[SEL_W-2:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_o5        <= 1'b0;
            r_o6        <= 1'b0;
        end else begin
            r_out_valid <= i_sel_valid;
            if (i_sel_valid) begin
                r_o6 <= i_table[i_sel];
                r_o5 <= i_table[w_sel5];
            end
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_o5        = r_o5;
    assign o_o6        = r_o6;

endmodule

// File: rtl/lut6_2_reconfig_ctrl.sv
// Reconfigurable LUT6_2: serial shadow load then atomic commit; load takes 64/BITS_PER_CYCLE+2 cycles.
// cfg_ready is low for the whole load; lookups never stall and see only whole tables.
module lut6_2_reconfig_ctrl
    import lut6_2_cfg_pkg::*;
#(
    parameter logic [LUT_BITS-1:0] INIT           = 64'h0000000000000000,
    parameter int                  BITS_PER_CYCLE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [LUT_BITS-1:0] cfg_data,
    output logic                cfg_busy,
    output logic                swap_done,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel,
    output logic                out_valid,
    output logic                o5,
    output logic                o6
);

    localparam int         N    = shift_cycles(BITS_PER_CYCLE);
    localparam logic [6:0] LAST = 7'(N - 1);

    generate
        if (!bpc_legal(BITS_PER_CYCLE)) begin : g_bad_bpc
            $error("lut6_2_reconfig_ctrl: BITS_PER_CYCLE must be 1,2,4,8,16,32 or 64");
        end
    endgenerate

    cfg_state_t          r_state;
    logic [LUT_BITS-1:0] r_staging;
    logic [LUT_BITS-1:0] r_shadow;
    logic [LUT_BITS-1:0] r_active;
    logic [6:0]          r_count;
    logic                r_swap_done;
    logic [2*LUT_BITS-1:0] w_shift;

    // Shifting the {staging, shadow} pair right by B moves the low staging bits into the top
    // of shadow and zero-fills staging; this stays well-formed even when B equals the table width.
    assign w_shift = {r_staging, r_shadow} >> BITS_PER_CYCLE;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_staging   <= '0;
            r_shadow    <= '0;
            r_active    <= INIT;
            r_count     <= '0;
            r_swap_done <= 1'b0;
        end else begin
            r_swap_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (cfg_valid) begin
                        r_staging <= cfg_data;
                        r_count   <= '0;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_shadow  <= w_shift[LUT_BITS-1:0];
                    r_staging <= w_shift[2*LUT_BITS-1:LUT_BITS];
                    r_count   <= r_count + 7'd1;
                    if (r_count == LAST) begin
                        r_state <= COMMIT;
                    end
                end
                COMMIT: begin
                    r_active    <= r_shadow;
                    r_swap_done <= 1'b1;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cfg_ready = (r_state == IDLE);
    assign cfg_busy  = (r_state == SHIFT) || (r_state == COMMIT);
    assign swap_done = r_swap_done;

    lut6_2_dyn_lookup u_lookup (
        .clk         (clk),
        .reset       (reset),
        .i_table     (r_active),
        .i_sel_valid (sel_valid),
        .i_sel       (sel),
        .o_out_valid (out_valid),
        .o_o5        (o5),
        .o_o6        (o6)
    );

endmodule
